idli_sqi_ctrl_m: RTL and testbench

Parametrised SQI (quad-SPI) serial-memory controller.

- Sits between the idli core's memory request port and the top-level `uio` pins.
- Turns one single-word read or write request into a complete SQI transaction: command nibbles, address nibbles, dummy nibbles (reads only), then data nibbles.
- Generalises the fixed single-device SQI link: selectable address/data width, dummy length, and `NUM_CS` independent chip selects.

---
 rtl/idli_pkg.sv | 21 ++
 rtl/idli_sqi_shift_m.sv | 33 +++
 rtl/idli_sqi_ctrl_m.sv | 223 ++++++++++++++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its SQI memory controller.
package idli_pkg;

   typedef enum logic {
      SQI_IO_IN  = 1'b0,
      SQI_IO_OUT = 1'b1
   } sqi_io_mode_t;

   typedef enum logic [2:0] {
      SQI_IDLE  = 3'd0,
      SQI_CMD   = 3'd1,
      SQI_ADDR  = 3'd2,
      SQI_DUMMY = 3'd3,
      SQI_DATA  = 3'd4,
      SQI_DONE  = 3'd5
   } sqi_state_t;

   localparam logic [7:0] SQI_CMD_READ  = 8'h03;
   localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

endpackage

// File: rtl/idli_sqi_shift_m.sv
// Nibble-wide shift register: parallel load, shift towards the MS end with a
// new nibble entering at the LS end; exposes the top OUT_W bits.
module idli_sqi_shift_m #(
   parameter int W     = 16,
   parameter int OUT_W = W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [W-1:0]     load_val,
   input  logic             shift,
   input  logic [3:0]       nib_in,
   output logic [OUT_W-1:0] q_out
);

   logic [W-1:0] q_r;

   // Load has priority over shift; the MS nibble falls off on every shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= '0;
      end else if (load) begin
         q_r <= load_val;
      end else if (shift) begin
         q_r <= W'({q_r, nib_in});
      end else begin
         q_r <= q_r;
      end
   end

   assign q_out = q_r[W-1 -: OUT_W];

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI (quad-SPI) memory controller: expands one word read/write request into
// command, address, optional dummy and data nibbles on a single chip select.
module idli_sqi_ctrl_m
   import idli_pkg::*;
#(
   parameter int  ADDR_W    = 16,
   parameter int  DATA_W    = 16,
   parameter int  DUMMY_NIB = 2,
   parameter int  NUM_CS    = 2,
   localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              i_sqi_gck,
   input  logic              i_sqi_rst_n,
   input  logic              i_sqi_req,
   output logic              o_sqi_ack,
   input  logic              i_sqi_wr,
   input  logic [CS_W-1:0]   i_sqi_cs_sel,
   input  logic [ADDR_W-1:0] i_sqi_addr,
   input  logic [DATA_W-1:0] i_sqi_wdata,
   output logic [DATA_W-1:0] o_sqi_rdata,
   output logic              o_sqi_rvld,
   output logic              o_sqi_busy,
   output logic              o_sqi_sck,
   output logic [NUM_CS-1:0] o_sqi_cs,
   output logic              o_sqi_io_mode,
   output logic [3:0]        o_sqi_sio,
   input  logic [3:0]        i_sqi_sio
);

   localparam int ADDR_NIB = ADDR_W / 4;
   localparam int DATA_NIB = DATA_W / 4;
   localparam int MAX_N    = 2 + ADDR_NIB + DUMMY_NIB + DATA_NIB;
   localparam int CNT_W    = $clog2(MAX_N);
   localparam int TX_W     = 8 + ADDR_W + DATA_W;

   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_NIB - 1);
   localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'((DUMMY_NIB > 0) ? DUMMY_NIB - 1 : 0);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_NIB - 1);

   sqi_state_t          state_r;
   sqi_state_t          next_state_s;
   sqi_io_mode_t        io_mode_r;
   sqi_io_mode_t        next_io_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    last_s;
   logic                phase_r;
   logic                wr_r;
   logic                cs_ok_r;
   logic                cs_ok_s;
   logic [NUM_CS-1:0]   cs_dec_s;
   logic [NUM_CS-1:0]   cs_r;
   logic                sck_r;
   logic                rvld_r;
   logic                busy_r;
   logic [DATA_W-1:0]   rdata_r;
   logic [DATA_W-1:0]   rx_q_s;
   logic [DATA_W-1:0]   rx_next_s;
   logic [3:0]          tx_nib_s;
   logic [TX_W-1:0]     tx_load_s;
   logic                tx_shift_s;
   logic                rx_shift_s;
   logic                ack_s;

   assign ack_s      = i_sqi_req & (state_r == SQI_IDLE);
   assign cs_ok_s    = 32'(i_sqi_cs_sel) < 32'(NUM_CS);
   // An out-of-range select shifts a zero, leaving every chip select high.
   assign cs_dec_s   = ~(NUM_CS'(cs_ok_s) << i_sqi_cs_sel);
   assign tx_load_s  = {(i_sqi_wr ? SQI_CMD_WRITE : SQI_CMD_READ), i_sqi_addr,
                        (i_sqi_wr ? i_sqi_wdata : DATA_W'(0))};
   assign tx_shift_s = phase_r & ((state_r == SQI_CMD) | (state_r == SQI_ADDR) |
                                  ((state_r == SQI_DATA) & wr_r));
   assign rx_shift_s = phase_r & (state_r == SQI_DATA) & ~wr_r;
   assign rx_next_s  = DATA_W'({rx_q_s, i_sqi_sio});

   idli_sqi_shift_m #(.W(TX_W), .OUT_W(4)) u_tx (
      .clk      (i_sqi_gck),
      .rst_n    (i_sqi_rst_n),
      .load     (ack_s),
      .load_val (tx_load_s),
      .shift    (tx_shift_s),
      .nib_in   (4'h0),
      .q_out    (tx_nib_s)
   );

   idli_sqi_shift_m #(.W(DATA_W), .OUT_W(DATA_W)) u_rx (
      .clk      (i_sqi_gck),
      .rst_n    (i_sqi_rst_n),
      .load     (ack_s),
      .load_val ({DATA_W{1'b0}}),
      .shift    (rx_shift_s),
      .nib_in   (i_sqi_sio),
      .q_out    (rx_q_s)
   );

   // Per-state nibble count and successor state / drive direction.
   always_comb begin
      last_s       = CMD_LAST;
      next_state_s = SQI_IDLE;
      next_io_s    = SQI_IO_IN;
      case (state_r)
         SQI_CMD: begin
            last_s       = CMD_LAST;
            next_state_s = SQI_ADDR;
            next_io_s    = SQI_IO_OUT;
         end
         SQI_ADDR: begin
            last_s = ADDR_LAST;
            if (!wr_r && (DUMMY_NIB > 0)) begin
               next_state_s = SQI_DUMMY;
               next_io_s    = SQI_IO_IN;
            end else begin
               next_state_s = SQI_DATA;
               next_io_s    = wr_r ? SQI_IO_OUT : SQI_IO_IN;
            end
         end
         SQI_DUMMY: begin
            last_s       = DUMMY_LAST;
            next_state_s = SQI_DATA;
            next_io_s    = SQI_IO_IN;
         end
         SQI_DATA: begin
            last_s       = DATA_LAST;
            next_state_s = SQI_DONE;
            next_io_s    = SQI_IO_IN;
         end
         default: begin
            last_s       = CMD_LAST;
            next_state_s = SQI_IDLE;
            next_io_s    = SQI_IO_IN;
         end
      endcase
   end

   // Transaction FSM; every pin-facing output is a register updated here.
   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         state_r   <= SQI_IDLE;
         io_mode_r <= SQI_IO_IN;
         cnt_r     <= '0;
         phase_r   <= 1'b0;
         wr_r      <= 1'b0;
         cs_ok_r   <= 1'b0;
         cs_r      <= '1;
         sck_r     <= 1'b0;
         rvld_r    <= 1'b0;
         busy_r    <= 1'b0;
         rdata_r   <= '0;
      end else begin
         rvld_r <= 1'b0;
         case (state_r)
            SQI_IDLE: begin
               phase_r <= 1'b0;
               cnt_r   <= '0;
               sck_r   <= 1'b0;
               if (i_sqi_req) begin
                  state_r   <= SQI_CMD;
                  wr_r      <= i_sqi_wr;
                  cs_ok_r   <= cs_ok_s;
                  cs_r      <= cs_dec_s;
                  io_mode_r <= SQI_IO_OUT;
                  busy_r    <= 1'b1;
               end else begin
                  state_r <= SQI_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            SQI_CMD, SQI_ADDR, SQI_DUMMY, SQI_DATA: begin
               phase_r <= ~phase_r;
               sck_r   <= ~phase_r;
               if (phase_r && (cnt_r == last_s)) begin
                  cnt_r     <= '0;
                  state_r   <= next_state_s;
                  io_mode_r <= next_io_s;
                  if (state_r == SQI_DATA) begin
                     cs_r   <= '1;
                     rvld_r <= ~wr_r;
                     if (!wr_r) begin
                        rdata_r <= cs_ok_r ? rx_next_s : '0;
                     end else begin
                        rdata_r <= rdata_r;
                     end
                  end else begin
                     cs_r <= cs_r;
                  end
               end else if (phase_r) begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            SQI_DONE: begin
               sck_r   <= 1'b0;
               phase_r <= ~phase_r;
               if (phase_r) begin
                  state_r <= SQI_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= SQI_DONE;
               end
            end
            default: begin
               state_r   <= SQI_IDLE;
               io_mode_r <= SQI_IO_IN;
               cs_r      <= '1;
               sck_r     <= 1'b0;
               busy_r    <= 1'b0;
               phase_r   <= 1'b0;
            end
         endcase
      end
   end

   assign o_sqi_ack     = ack_s;
   assign o_sqi_rdata   = rdata_r;
   assign o_sqi_rvld    = rvld_r;
   assign o_sqi_busy    = busy_r;
   assign o_sqi_sck     = sck_r;
   assign o_sqi_cs      = cs_r;
   assign o_sqi_io_mode = io_mode_r;
   assign o_sqi_sio     = tx_nib_s;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: a default instance and a narrow-parameter instance
// share stimulus; expected nibbles and read words flow through scoreboard queues.
module tb_idli_sqi_ctrl_m;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        wr;
   logic        cs_sel;
   logic [23:0] addr;
   logic [15:0] wdata;
   logic [3:0]  sio_in;
   int          sel;

   logic        ack0, rvld0, busy0, sck0, io0;
   logic [15:0] rdata0;
   logic [1:0]  cs0;
   logic [3:0]  sio0;
   logic        ack1, rvld1, busy1, sck1, io1;
   logic [7:0]  rdata1;
   logic [0:0]  cs1;
   logic [3:0]  sio1;

   logic        s_ack, s_rvld, s_busy, s_sck, s_io;
   logic [15:0] s_rdata;
   logic [1:0]  s_cs;
   logic [3:0]  s_sio;

   int          errors = 0;
   int          checks = 0;
   logic [3:0]  exp_nib[$];
   logic [15:0] exp_rd[$];

   always #5 clk = ~clk;

   idli_sqi_ctrl_m dut0 (
      .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req(req && (sel == 0)),
      .o_sqi_ack(ack0), .i_sqi_wr(wr), .i_sqi_cs_sel(cs_sel),
      .i_sqi_addr(addr[15:0]), .i_sqi_wdata(wdata), .o_sqi_rdata(rdata0),
      .o_sqi_rvld(rvld0), .o_sqi_busy(busy0), .o_sqi_sck(sck0), .o_sqi_cs(cs0),
      .o_sqi_io_mode(io0), .o_sqi_sio(sio0), .i_sqi_sio(sio_in)
   );

   idli_sqi_ctrl_m #(.ADDR_W(24), .DATA_W(8), .DUMMY_NIB(0), .NUM_CS(1)) dut1 (
      .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req(req && (sel == 1)),
      .o_sqi_ack(ack1), .i_sqi_wr(wr), .i_sqi_cs_sel(cs_sel),
      .i_sqi_addr(addr), .i_sqi_wdata(wdata[7:0]), .o_sqi_rdata(rdata1),
      .o_sqi_rvld(rvld1), .o_sqi_busy(busy1), .o_sqi_sck(sck1), .o_sqi_cs(cs1),
      .o_sqi_io_mode(io1), .o_sqi_sio(sio1), .i_sqi_sio(sio_in)
   );

   always_comb begin
      if (sel == 0) begin
         s_ack = ack0; s_rvld = rvld0; s_busy = busy0; s_sck = sck0; s_io = io0;
         s_rdata = rdata0; s_cs = cs0; s_sio = sio0;
      end else begin
         s_ack = ack1; s_rvld = rvld1; s_busy = busy1; s_sck = sck1; s_io = io1;
         s_rdata = {8'h00, rdata1}; s_cs = {1'b1, cs1}; s_sio = sio1;
      end
   end

   // One transaction on instance s; abort_at>0 asserts reset in that cycle,
   // exp_wait>0 demands the ack after exactly that many sampled cycles.
   task automatic run_txn(input int s, input bit w, input bit c, input logic [23:0] a,
                          input logic [15:0] wd, input logic [15:0] mem, input bit hold,
                          input int abort_at, input int exp_wait);
      int an, dn, dwn, n, waited, k, j;
      bit ok, exp_io;
      logic [7:0]  cmd;
      logic [1:0]  exp_cs;
      logic [3:0]  nib;
      logic [15:0] rd;
      sel = s; wr = w; cs_sel = c; addr = a; wdata = wd; req = 1'b1;
      an  = (s == 1) ? 6 : 4;
      dn  = (s == 1) ? 0 : 2;
      dwn = (s == 1) ? 2 : 4;
      n   = 2 + an + (w ? 0 : dn) + dwn;
      ok  = (s == 0) || (c == 1'b0);
      exp_cs = !ok ? 2'b11 : (c ? 2'b01 : 2'b10);
      cmd = w ? 8'h02 : 8'h03;
      exp_nib.push_back(cmd[7:4]);
      exp_nib.push_back(cmd[3:0]);
      for (int i = 0; i < an; i++) exp_nib.push_back(4'(a >> ((an - 1 - i) * 4)));
      if (w) begin
         for (int i = 0; i < dwn; i++) exp_nib.push_back(4'(wd >> ((dwn - 1 - i) * 4)));
      end else begin
         exp_rd.push_back(ok ? 16'(mem & ((1 << (dwn * 4)) - 1)) : 16'h0000);
      end
      waited = 0;
      do begin
         @(posedge clk); #1;
         @(negedge clk);
         waited++;
      end while (!s_ack && waited < 50);
      checks++;
      if (!s_ack) begin
         $display("FAIL ack_timeout: no ack after %0d cycles", waited);
         errors++;
         req = 1'b0;
         exp_nib.delete();
         exp_rd.delete();
         return;
      end
      if (exp_wait > 0) begin
         checks++;
         if (waited !== exp_wait) begin
            $display("FAIL ack_latency: got %0d cycles want %0d", waited, exp_wait);
            errors++;
         end
      end
      checks++;
      if (s_busy !== 1'b0) begin
         $display("FAIL busy_at_ack: got %b want 0", s_busy);
         errors++;
      end
      for (int t = 1; t <= 2 * n + 2; t++) begin
         k = (t - 1) / 2;
         j = k - (2 + an + dn);
         @(posedge clk); #1;
         if (t == 1 && !hold) begin
            req = 1'b0; wr = ~w; cs_sel = ~c; addr = ~a; wdata = ~wd;
         end
         sio_in = (!w && j >= 0 && j < dwn) ? 4'(mem >> ((dwn - 1 - j) * 4)) : 4'h0;
         @(negedge clk);
         exp_io = w || (k < 2 + an);
         checks += 4;
         if (t <= 2 * n) begin
            if (s_cs !== exp_cs) begin
               $display("FAIL cs t=%0d: got %b want %b", t, s_cs, exp_cs); errors++;
            end
            if (s_sck !== ((t % 2) == 0)) begin
               $display("FAIL sck t=%0d: got %b want %b", t, s_sck, (t % 2) == 0); errors++;
            end
            if (s_io !== exp_io) begin
               $display("FAIL io_mode t=%0d: got %b want %b", t, s_io, exp_io); errors++;
            end
            if (exp_io && (t % 2) == 0) begin
               checks++;
               if (exp_nib.size() == 0) begin
                  $display("FAIL sio_extra t=%0d: got %h want none", t, s_sio); errors++;
               end else begin
                  nib = exp_nib.pop_front();
                  if (s_sio !== nib) begin
                     $display("FAIL sio t=%0d: got %h want %h", t, s_sio, nib); errors++;
                  end
               end
            end
         end else begin
            if (s_cs !== 2'b11) begin
               $display("FAIL cs_done t=%0d: got %b want 11", t, s_cs); errors++;
            end
            if (s_sck !== 1'b0) begin
               $display("FAIL sck_done t=%0d: got %b want 0", t, s_sck); errors++;
            end
            if (s_io !== 1'b0) begin
               $display("FAIL io_done t=%0d: got %b want 0", t, s_io); errors++;
            end
         end
         if (s_busy !== 1'b1 || s_ack !== 1'b0) begin
            $display("FAIL busy_ack t=%0d: got busy=%b ack=%b want 1 0", t, s_busy, s_ack); errors++;
         end
         checks++;
         if (s_rvld !== (!w && t == 2 * n + 1)) begin
            $display("FAIL rvld t=%0d: got %b want %b", t, s_rvld, !w && t == 2 * n + 1); errors++;
         end
         if (s_rvld === 1'b1 && exp_rd.size() > 0) begin
            rd = exp_rd.pop_front();
            checks++;
            if (s_rdata !== rd) begin
               $display("FAIL rdata: got %h want %h", s_rdata, rd); errors++;
            end
         end
         if (t == abort_at) begin
            #1 rst_n = 1'b0;
            #1;
            checks++;
            if ({s_cs, s_sck, s_io, s_sio, s_rvld, s_busy, s_rdata} !== {2'b11, 8'h00, 16'h0000}) begin
               $display("FAIL async_reset: got cs=%b sck=%b io=%b sio=%h rvld=%b busy=%b rdata=%h want 11 0 0 0 0 0 0000",
                        s_cs, s_sck, s_io, s_sio, s_rvld, s_busy, s_rdata);
               errors++;
            end
            exp_nib.delete();
            exp_rd.delete();
            req = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
            return;
         end
      end
      checks++;
      if (exp_nib.size() != 0 || exp_rd.size() != 0) begin
         $display("FAIL leftover: got %0d nibbles %0d words pending want 0 0", exp_nib.size(), exp_rd.size());
         errors++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 1'b0; wr = 1'b0; cs_sel = 1'b0; addr = '0; wdata = '0;
      sio_in = 4'h0; sel = 0;
      repeat (3) @(posedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         @(negedge clk);
         checks++;
         if ({s_cs, s_sck, s_io, s_sio, s_rvld, s_busy, s_ack, s_rdata} !== {2'b11, 9'h000, 16'h0000}) begin
            $display("FAIL reset_vals dut%0d: got cs=%b sck=%b io=%b sio=%h rvld=%b busy=%b ack=%b rdata=%h want 11 and zeros",
                     s, s_cs, s_sck, s_io, s_sio, s_rvld, s_busy, s_ack, s_rdata);
            errors++;
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_read();
      run_txn(0, 1'b0, 1'b1, 24'h001234, 16'h0000, 16'hBEEF, 1'b0, 0, 0);
   endtask

   task automatic test_write();
      run_txn(0, 1'b1, 1'b0, 24'h0000FF, 16'hA5C3, 16'h0000, 1'b0, 0, 0);
      run_txn(0, 1'b0, 1'b0, 24'h000ABC, 16'h0000, 16'h1357, 1'b0, 0, 1);
   endtask

   task automatic test_back_to_back();
      run_txn(0, 1'b0, 1'b1, 24'h004321, 16'h0000, 16'hCAFE, 1'b1, 0, 0);
      run_txn(0, 1'b0, 1'b0, 24'h008765, 16'h0000, 16'h0F1E, 1'b0, 0, 1);
   endtask

   task automatic test_sweep();
      run_txn(1, 1'b0, 1'b0, 24'hABCDEF, 16'h0000, 16'h005A, 1'b0, 0, 0);
      run_txn(1, 1'b1, 1'b0, 24'h123456, 16'h00C7, 16'h0000, 1'b0, 0, 0);
   endtask

   task automatic test_bad_cs();
      run_txn(1, 1'b0, 1'b1, 24'h000111, 16'h0000, 16'h0077, 1'b0, 0, 0);
   endtask

   task automatic test_async_reset();
      run_txn(0, 1'b0, 1'b0, 24'h002468, 16'h0000, 16'h9999, 1'b0, 9, 0);
      run_txn(0, 1'b0, 1'b1, 24'h001357, 16'h0000, 16'hBEEF, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_sweep();
      test_bad_cs();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
